// File: rtl/shift_sub_div_pkg.sv
// Shared types and constants for the shift-subtract divider: FSM state enum,
// default operand width and the iteration-counter width helper.
package shift_sub_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_sub_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module shift_sub_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic           unused_rem_msb;

  // The remainder MSB is always zero between iterations; only the low bits shift.
  assign unused_rem_msb = rem_in[WIDTH];
  assign shifted        = {rem_in[WIDTH-1:0], dividend_bit};

  always_comb begin
    rem_out = shifted;
    q_bit   = 1'b0;
    if (shifted >= {1'b0, divisor}) begin
      rem_out = shifted - {1'b0, divisor};
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Optional feature macro: SHIFT_SUB_DIV_ZERO_FLAG_EN (div_by_zero port, early exit).
module shift_sub_divider
  import shift_sub_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       state_dbg,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef SHIFT_SUB_DIV_ZERO_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   step_rem;
  logic             step_qbit;
`ifdef SHIFT_SUB_DIV_ZERO_FLAG_EN
  logic             dz_q, dz_d;
`endif

  shift_sub_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_q),
    .dividend_bit (dq_q[WIDTH-1]),
    .divisor      (dvs_q),
    .rem_out      (step_rem),
    .q_bit        (step_qbit)
  );

  // Handshake: a transfer happens on a rising edge where valid && ready; both
  // in_ready and out_valid decode from state only, never from inputs.
  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
`ifdef SHIFT_SUB_DIV_ZERO_FLAG_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dq_d    = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = CALC;
`ifdef SHIFT_SUB_DIV_ZERO_FLAG_EN
          dz_d    = 1'b0;
`endif
        end
      end
      CALC: begin
        dq_d  = {dq_q[WIDTH-2:0], step_qbit};
        rem_d = step_rem;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`ifdef SHIFT_SUB_DIV_ZERO_FLAG_EN
        // Only the first CALC cycle can see a zero divisor, so dq_q is still the dividend.
        if (dvs_q == '0) begin
          dq_d    = '1;
          rem_d   = {1'b0, dq_q};
          dz_d    = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dq_q    <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
`ifdef SHIFT_SUB_DIV_ZERO_FLAG_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
`ifdef SHIFT_SUB_DIV_ZERO_FLAG_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign state_dbg = state_q;
  assign quotient  = dq_q;
  assign remainder = rem_q[WIDTH-1:0];
`ifdef SHIFT_SUB_DIV_ZERO_FLAG_EN
  assign div_by_zero = dz_q;
`endif

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed plus randomized bench for shift_sub_divider against an arithmetic
// reference model; honours SHIFT_SUB_DIV_ZERO_FLAG_EN when defined.
module tb_shift_sub_divider;

  localparam int W  = 8;
  localparam int EW = 2 * W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready;
  logic         out_valid;
  logic [1:0]   state_dbg;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef SHIFT_SUB_DIV_ZERO_FLAG_EN
  logic         div_by_zero;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .state_dbg   (state_dbg),
    .quotient    (quotient),
    .remainder   (remainder)
`ifdef SHIFT_SUB_DIV_ZERO_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: {div_by_zero, quotient, remainder}
  function automatic logic [EW-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) begin
      q = '1;
      r = a;
      return {1'b1, q, r};
    end
    q = a / b;
    r = a % b;
    return {1'b0, q, r};
  endfunction

  // Driver: called at a negedge with the DUT idle; leaves it idle at a negedge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit keep_valid);
    logic [EW-1:0] e;
    int k;
    int lat;
    exp_q.push_back(ref_div(a, b));
    lat = W;
`ifdef SHIFT_SUB_DIV_ZERO_FLAG_EN
    if (b == '0) lat = 1;
`endif
    check("idle_in_ready", 32'(in_ready), 32'd1);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 64) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(lat));
    check("done_in_ready", 32'(in_ready), 32'd0);
    e = exp_q.pop_front();
    check("quotient", 32'(quotient), 32'(e[2*W-1:W]));
    check("remainder", 32'(remainder), 32'(e[W-1:0]));
`ifdef SHIFT_SUB_DIV_ZERO_FLAG_EN
    check("div_by_zero", 32'(div_by_zero), 32'(e[2*W]));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("held_valid", 32'(out_valid), 32'd1);
      check("held_quotient", 32'(quotient), 32'(e[2*W-1:W]));
      check("held_remainder", 32'(remainder), 32'(e[W-1:0]));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("single_transfer", 32'(out_valid), 32'd0);
    check("back_idle", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int rh;
    bit rk;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
`ifdef SHIFT_SUB_DIV_ZERO_FLAG_EN
    check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(8'd15, 8'd5, 0, 1'b0);
    run_op(8'd81, 8'd9, 0, 1'b1);
    run_op(8'd200, 8'd7, 0, 1'b1);
    run_op(8'd255, 8'd1, 0, 1'b1);
    in_valid = 1'b0;
    run_op(8'd10, 8'd0, 0, 1'b0);
    run_op(8'd200, 8'd7, 5, 1'b0);

    // Abort mid-calculation with reset after iteration 4
    dividend = 8'd100;
    divisor  = 8'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(8'd100, 8'd3, 0, 1'b0);

    run_op(8'd0, 8'd10, 0, 1'b0);
    run_op(8'd7, 8'd9, 0, 1'b0);

    // Randomized operations with random backpressure and held in_valid
    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
      rh = $urandom_range(0, 3);
      rk = 1'($urandom_range(0, 1));
      run_op(ra, rb, rh, rk);
    end
    in_valid = 1'b0;
    @(negedge clk);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
